rr_validready_arbiter: RTL and testbench

//  N-to-1 round-robin arbiter sharing one valid/ready pipeline stage among N upstream requesters.

---
 rtl/rr_validready_arbiter.sv | 100 ++++++++++
 tb/tb_rr_validready_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_validready_arbiter.sv
// N-to-1 packet-aware round-robin arbiter feeding a registered one-entry valid/ready stage.
// A grant is held from a packet's first beat until its last beat is accepted.
module rr_validready_arbiter #(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int IW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       up_valid,
    input  logic [N-1:0]       up_last,
    input  logic [N*WIDTH-1:0] up_data,
    output logic [N-1:0]       up_ready,
    output logic               down_valid,
    output logic               down_last,
    output logic [WIDTH-1:0]   down_data,
    output logic [IW-1:0]      down_src,
    input  logic               down_ready,
    output logic               locked
);

    logic             r_down_valid;
    logic             r_down_last;
    logic [WIDTH-1:0] r_down_data;
    logic [IW-1:0]    r_down_src;
    logic             r_locked;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;

    logic             w_accept;
    logic             w_arb_valid;
    logic [IW-1:0]    w_arb_idx;
    logic             w_grant_valid;
    logic [IW-1:0]    w_winner;
    logic             w_up_fire;
    logic [IW-1:0]    w_ptr_next;

    // Ready is held low while reset is asserted so no requester sees a handshake mid-reset.
    assign w_accept = rst_n & (~r_down_valid | down_ready);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_arb_valid = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_arb_valid && up_valid[(int'(r_ptr) + k) % N]) begin
                w_arb_valid = 1'b1;
                w_arb_idx   = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    // While locked the owner keeps the grant; its valid dropping just pauses the packet.
    assign w_winner      = r_locked ? r_owner : w_arb_idx;
    assign w_grant_valid = r_locked ? up_valid[r_owner] : w_arb_valid;
    assign w_up_fire     = w_accept & w_grant_valid;
    assign w_ptr_next    = (w_winner == IW'(N - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        up_ready = '0;
        if (w_up_fire) begin
            up_ready[w_winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_down_valid <= 1'b0;
            r_down_last  <= 1'b0;
            r_down_data  <= '0;
            r_down_src   <= '0;
            r_locked     <= 1'b0;
            r_ptr        <= '0;
            r_owner      <= '0;
        end else if (w_up_fire) begin
            // A new beat may overwrite a draining one in the same edge: no bubble.
            r_down_valid <= 1'b1;
            r_down_last  <= up_last[w_winner];
            r_down_data  <= up_data[int'(w_winner) * WIDTH +: WIDTH];
            r_down_src   <= w_winner;
            if (up_last[w_winner]) begin
                r_locked <= 1'b0;
                r_ptr    <= w_ptr_next;
            end else begin
                r_locked <= 1'b1;
                r_owner  <= w_winner;
            end
        end else if (r_down_valid && down_ready) begin
            r_down_valid <= 1'b0;
        end
    end

    assign down_valid = r_down_valid;
    assign down_last  = r_down_last;
    assign down_data  = r_down_data;
    assign down_src   = r_down_src;
    assign locked     = r_locked;

endmodule

// File: tb/tb_rr_validready_arbiter.sv
// Self-checking bench: per-requester beat queues drive the arbiter, a behavioural model
// predicts every output each cycle, and directed scenarios pin grant orders with literals.
module tb_rr_validready_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   up_valid;
    logic [N-1:0]   up_last;
    logic [N*W-1:0] up_data;
    logic [N-1:0]   up_ready;
    logic           down_valid;
    logic           down_last;
    logic [W-1:0]   down_data;
    logic [1:0]     down_src;
    logic           down_ready;
    logic           locked;

    rr_validready_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_last    (up_last),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_last  (down_last),
        .down_data  (down_data),
        .down_src   (down_src),
        .down_ready (down_ready),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pending beats of each requester, and a per-requester mask that pauses its valid.
    beat_t q[N][$];
    bit    hold[N];

    // Model: the output stage contents plus round-robin pointer and lock owner.
    int           m_ptr;
    int           m_owner;
    bit           m_locked;
    bit           m_dv;
    bit           m_dl;
    logic [W-1:0] m_dd;
    int           m_ds;
    int           m_log[$];
    int           d_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int got[$], input int exp[$]);
        check({name, " length"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    function automatic beat_t mk(input int src, input int tag, input bit last);
        beat_t b;
        b.data = {8'(src), 8'hB0, 16'(tag)};
        b.last = last;
        return b;
    endfunction

    // Who should hold the grant given the model state and the requests currently presented.
    function automatic void m_grant(output bit gv, output int w);
        gv = 1'b0;
        w  = 0;
        if (m_locked) begin
            w  = m_owner;
            gv = up_valid[w];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gv && up_valid[(m_ptr + k) % N]) begin
                    gv = 1'b1;
                    w  = (m_ptr + k) % N;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        bit           gv;
        int           w;
        logic [N-1:0] r;
        r = '0;
        m_grant(gv, w);
        if (rst_n === 1'b1 && gv && (!m_dv || down_ready === 1'b1)) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 1'b0;
        m_dv     = 1'b0;
        m_dl     = 1'b0;
        m_dd     = '0;
        m_ds     = 0;
    endtask

    // Applied just after an active edge, using the inputs that were stable before it.
    task automatic model_step();
        bit gv;
        int w;
        if (rst_n !== 1'b1) return;
        m_grant(gv, w);
        if (m_dv && down_ready) m_log.push_back(m_ds);
        if (gv && (!m_dv || down_ready)) begin
            m_dd = q[w][0].data;
            m_dl = q[w][0].last;
            m_ds = w;
            m_dv = 1'b1;
            if (m_dl) begin
                m_locked = 1'b0;
                m_ptr    = (w + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = w;
            end
            void'(q[w].pop_front());
        end else if (m_dv && down_ready) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            up_valid[i]          = (q[i].size() > 0) && !hold[i];
            up_data[i*W +: W]    = (q[i].size() > 0) ? q[i][0].data : '0;
            up_last[i]           = (q[i].size() > 0) ? q[i][0].last : 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        drive_inputs();
    endtask

    task automatic clear_logs();
        d_log.delete();
        m_log.delete();
    endtask

    // Compare process: every output against the model, once per cycle away from the active edge.
    always @(negedge clk) begin
        check("down_valid", 64'(down_valid), 64'(m_dv));
        check("down_last", 64'(down_last), 64'(m_dl));
        check("down_data", 64'(down_data), 64'(m_dd));
        check("down_src", 64'(down_src), 64'(m_ds));
        check("locked", 64'(locked), 64'(m_locked));
        check("up_ready", 64'(up_ready), 64'(exp_ready()));
        if (down_valid === 1'b1 && down_ready === 1'b1) d_log.push_back(int'(down_src));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq[$];

        // 1 + 2: reset with everyone requesting, then single-beat fairness.
        rst_n      = 1'b0;
        down_ready = 1'b1;
        up_valid   = '0;
        up_last    = '0;
        up_data    = '0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        q[0].push_back(mk(0, 1, 1'b1));
        q[0].push_back(mk(0, 2, 1'b1));
        q[1].push_back(mk(1, 1, 1'b1));
        q[1].push_back(mk(1, 2, 1'b1));
        q[2].push_back(mk(2, 1, 1'b1));
        q[3].push_back(mk(3, 1, 1'b1));
        model_reset();
        drive_inputs();
        cycle();
        cycle();
        #1;
        check("reset up_ready", 64'(up_ready), 64'h0);
        check("reset down_valid", 64'(down_valid), 64'h0);
        check("reset locked", 64'(locked), 64'h0);
        #2 rst_n = 1'b1;
        #1;
        check("first grant after reset", 64'(up_ready), 64'h1);
        repeat (8) cycle();
        exp_seq = '{0, 1, 2, 3, 0, 1};
        check_seq("fairness dut", d_log, exp_seq);
        check_seq("fairness model", m_log, exp_seq);

        // Walk the pointer from 2 round to 1 with single beats.
        q[2].push_back(mk(2, 3, 1'b1));
        q[3].push_back(mk(3, 3, 1'b1));
        q[0].push_back(mk(0, 3, 1'b1));
        drive_inputs();
        repeat (5) cycle();
        clear_logs();

        // 3: req1's three-beat packet holds the grant against req0 and req2.
        q[1].push_back(mk(1, 10, 1'b0));
        q[1].push_back(mk(1, 11, 1'b0));
        q[1].push_back(mk(1, 12, 1'b1));
        q[0].push_back(mk(0, 10, 1'b1));
        q[2].push_back(mk(2, 10, 1'b1));
        drive_inputs();
        repeat (8) cycle();
        exp_seq = '{1, 1, 1, 2, 0};
        check_seq("lock dut", d_log, exp_seq);
        check_seq("lock model", m_log, exp_seq);
        clear_logs();

        // 4: downstream stalls for five cycles with 0xA5A5A5A5 held.
        down_ready = 1'b0;
        q[1].push_back('{data: 32'hA5A5_A5A5, last: 1'b1});
        q[2].push_back(mk(2, 20, 1'b1));
        drive_inputs();
        #1;
        check("stall first grant", 64'(up_ready), 64'h2);
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall down_data", 64'(down_data), 64'hA5A5_A5A5);
            check("stall up_ready", 64'(up_ready), 64'h0);
            cycle();
        end
        down_ready = 1'b1;
        repeat (5) cycle();
        exp_seq = '{1, 2};
        check_seq("stall dut", d_log, exp_seq);
        check_seq("stall model", m_log, exp_seq);
        clear_logs();

        // 5: lock owner req3 pauses two cycles mid-packet; req0 must keep waiting.
        q[3].push_back(mk(3, 30, 1'b0));
        q[3].push_back(mk(3, 31, 1'b0));
        q[3].push_back(mk(3, 32, 1'b1));
        q[0].push_back(mk(0, 30, 1'b1));
        drive_inputs();
        #1;
        hold[3] = 1'b1;
        cycle();
        #1;
        check("gap1 locked", 64'(locked), 64'h1);
        check("gap1 up_ready", 64'(up_ready), 64'h0);
        cycle();
        #1;
        check("gap2 locked", 64'(locked), 64'h1);
        check("gap2 up_ready", 64'(up_ready), 64'h0);
        hold[3] = 1'b0;
        repeat (7) cycle();
        exp_seq = '{3, 3, 3, 0};
        check_seq("gap dut", d_log, exp_seq);
        check_seq("gap model", m_log, exp_seq);
        clear_logs();

        // 6: asynchronous reset while req2's second beat is presented.
        q[2].push_back(mk(2, 40, 1'b0));
        q[2].push_back(mk(2, 41, 1'b0));
        q[2].push_back(mk(2, 42, 1'b1));
        drive_inputs();
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset down_valid", 64'(down_valid), 64'h0);
        check("async reset locked", 64'(locked), 64'h0);
        clear_logs();
        for (int i = 0; i < N; i++) q[i].delete();
        q[0].push_back(mk(0, 50, 1'b1));
        q[1].push_back(mk(1, 50, 1'b1));
        q[2].push_back(mk(2, 40, 1'b0));
        q[2].push_back(mk(2, 41, 1'b0));
        q[2].push_back(mk(2, 42, 1'b1));
        q[3].push_back(mk(3, 50, 1'b1));
        drive_inputs();
        cycle();
        #1;
        rst_n = 1'b1;
        #1;
        check("ptr zero after reset", 64'(up_ready), 64'h1);
        repeat (10) cycle();
        exp_seq = '{0, 1, 2, 2, 2, 3};
        check_seq("restart dut", d_log, exp_seq);
        check_seq("restart model", m_log, exp_seq);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
